// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encoding and default latencies.
package mdu_pkg;

  // The decoder's mulDiv class is driven straight onto this encoding.
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_MFHI  = 3'd6,
    MDU_MFLO  = 3'd7
  } mdu_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic op_is_signed(mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic core: full-width product, truncating quotient and
// dividend-signed remainder, plus the divide-by-zero flag.
module mdu_arith #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem,
  output logic               div_zero
);

  logic               a_neg;
  logic               b_neg;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   b_safe;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;

  always_comb begin
    a_neg = is_signed & a[WIDTH-1];
    b_neg = is_signed & b[WIDTH-1];

    // Low 2*WIDTH bits of the extended product are exact for both signednesses.
    a_ext = {{WIDTH{a_neg}}, a};
    b_ext = {{WIDTH{b_neg}}, b};
    prod  = a_ext * b_ext;

    div_zero = (b == '0);
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    b_safe   = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;

    // min_int / -1: magnitude quotient is 2^(WIDTH-1), positive sign, so it
    // wraps to min_int with a zero remainder without a dedicated path.
    q_mag = a_mag / b_safe;
    r_mag = a_mag % b_safe;

    quot = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem  = a_neg ? -r_mag : r_mag;
  end

endmodule

// File: rtl/mdu_hilo.sv
// EX-stage multiply/divide unit with architectural HI/LO. Results are held in
// pending registers and committed when the fixed-latency busy counter expires.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  mdu_op_e          op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             cancel,
  input  logic             rd_sel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   pend_hi;
  logic [WIDTH-1:0]   pend_lo;
  logic               pend_ok;
  logic               accept;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic               div_zero;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .a         (rs_data),
    .b         (rt_data),
    .is_signed (op_is_signed(op)),
    .prod      (prod),
    .quot      (quot),
    .rem       (rem),
    .div_zero  (div_zero)
  );

  assign busy    = (cnt != '0);
  assign accept  = start & ~cancel & ~busy;
  assign rd_data = rd_sel ? hi : lo;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_ok <= 1'b0;
    end else if (busy) begin
      // In-flight ops ignore cancel and any new start until they retire.
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1) && pend_ok) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (accept) begin
      case (op)
        MDU_MULT, MDU_MULTU: begin
          pend_hi <= prod[2*WIDTH-1:WIDTH];
          pend_lo <= prod[WIDTH-1:0];
          pend_ok <= 1'b1;
          cnt     <= CW'(MULT_CYCLES);
        end
        MDU_DIV, MDU_DIVU: begin
          pend_hi <= rem;
          pend_lo <= quot;
          pend_ok <= ~div_zero;
          cnt     <= CW'(DIV_CYCLES);
        end
        MDU_MTHI: hi <= rs_data;
        MDU_MTLO: lo <= rs_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a cycle-count reference model.
module tb_mdu_hilo;
  import mdu_pkg::*;

  localparam int W     = 32;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  mdu_op_e       op;
  logic [W-1:0]  rs_data;
  logic [W-1:0]  rt_data;
  logic          cancel;
  logic          rd_sel;
  logic          busy;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic [W-1:0]  rd_data;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  mdu_hilo dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .cancel  (cancel),
    .rd_sel  (rd_sel),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .rd_data (rd_data)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // The result of an accepted mult/div becomes visible at edge number done_at;
  // the unit is busy while the edge count has not yet reached it.
  longint       edge_n  = 0;
  longint       done_at = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic [W-1:0] p_hi = '0;
  logic [W-1:0] p_lo = '0;
  logic         p_ok = 1'b0;

  always @(posedge clk) begin
    longint       sa, sb, sq, sr;
    logic [63:0]  wide;
    logic [63:0]  wq;
    logic [63:0]  wr;
    edge_n = edge_n + 1;
    if (!reset) begin
      m_hi = '0; m_lo = '0; done_at = 0; p_ok = 1'b0;
    end else if (done_at >= edge_n) begin
      if (done_at == edge_n && p_ok) begin
        m_hi = p_hi; m_lo = p_lo;
      end
    end else if (start && !cancel) begin
      sa = longint'($signed(rs_data));
      sb = longint'($signed(rt_data));
      case (op)
        MDU_MULT: begin
          wide = 64'(sa * sb);
          p_hi = wide[63:32]; p_lo = wide[31:0]; p_ok = 1'b1;
          done_at = edge_n + MULT_N;
        end
        MDU_MULTU: begin
          wide = {32'b0, rs_data} * {32'b0, rt_data};
          p_hi = wide[63:32]; p_lo = wide[31:0]; p_ok = 1'b1;
          done_at = edge_n + MULT_N;
        end
        MDU_DIV: begin
          p_ok = (rt_data != 0);
          if (rs_data == 32'h8000_0000 && rt_data == 32'hFFFF_FFFF) begin
            p_lo = 32'h8000_0000; p_hi = '0;
          end else if (p_ok) begin
            sq = sa / sb; sr = sa % sb;
            wq = 64'(sq); wr = 64'(sr);
            p_lo = wq[31:0]; p_hi = wr[31:0];
          end
          done_at = edge_n + DIV_N;
        end
        MDU_DIVU: begin
          p_ok = (rt_data != 0);
          if (p_ok) begin
            p_lo = rs_data / rt_data; p_hi = rs_data % rt_data;
          end
          done_at = edge_n + DIV_N;
        end
        MDU_MTHI: m_hi = rs_data;
        MDU_MTLO: m_lo = rs_data;
        default: ;
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy_cyc", W'(busy), W'(done_at > edge_n));
      check("hi_cyc", hi, m_hi);
      check("lo_cyc", lo, m_lo);
      check("rd_cyc", rd_data, rd_sel ? m_hi : m_lo);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input mdu_op_e o, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    start = 1'b1; op = o; rs_data = a; rt_data = b; cancel = c;
    tick();
    start = 1'b0; cancel = 1'b0;
  endtask

  // Counts cycles observed busy, bounded so a stuck busy cannot hang the run.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      tick();
    end
    if (n >= 64) check("idle_timeout", 32'(n), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return W'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; op = MDU_MFLO; rs_data = '0; rt_data = '0;
    cancel = 1'b0; rd_sel = 1'b0;
    tick(); tick(); tick();
    chk_en = 1'b1;
    check("rst_busy", W'(busy), '0);
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    check("rst_rd", rd_data, '0);
    reset = 1'b1;
    tick();

    issue(MDU_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    wait_idle(n);
    check("mult_lat", 32'(n), 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    issue(MDU_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    wait_idle(n);
    check("multu_lat", 32'(n), 32'd5);
    check("multu_hi", hi, 32'h0000_0002);
    check("multu_lo", lo, 32'hFFFF_FFFA);

    issue(MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    wait_idle(n);
    check("div_lat", 32'(n), 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    issue(MDU_DIVU, 32'h0000_0007, 32'h0000_0000, 1'b0);
    wait_idle(n);
    check("div0_lat", 32'(n), 32'd10);
    check("div0_hi", hi, 32'hFFFF_FFFF);
    check("div0_lo", lo, 32'hFFFF_FFFD);

    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle(n);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'h0000_0000);

    issue(MDU_MTHI, 32'h1234_5678, '0, 1'b1);
    check("mthi_cancel", hi, 32'h0000_0000);
    issue(MDU_MTHI, 32'h1234_5678, '0, 1'b0);
    rd_sel = 1'b1;
    #1;
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_busy", W'(busy), '0);
    check("mthi_rd", rd_data, 32'h1234_5678);
    rd_sel = 1'b0;

    // Cancel during flight and a stray start while busy must not disturb the op.
    issue(MDU_MULT, 32'h0000_0003, 32'h0000_0004, 1'b0);
    tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    issue(MDU_DIV, 32'h0000_0064, 32'h0000_0003, 1'b0);
    wait_idle(n);
    check("cancel_lat_tail", 32'(n), 32'd2);
    check("cancel_hi", hi, 32'h0000_0000);
    check("cancel_lo", lo, 32'h0000_000C);

    issue(MDU_DIV, 32'h0000_0064, 32'h0000_0007, 1'b0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rstmid_hi", hi, '0);
    check("rstmid_lo", lo, '0);
    check("rstmid_busy", W'(busy), '0);
    reset = 1'b1;
    repeat (15) tick();
    check("rstmid_late_hi", hi, '0);
    check("rstmid_late_lo", lo, '0);

    for (int i = 0; i < 600; i++) begin
      start   = ($urandom_range(0, 2) != 0);
      op      = mdu_op_e'($urandom_range(0, 7));
      rs_data = pick_operand();
      rt_data = pick_operand();
      cancel  = ($urandom_range(0, 7) == 0);
      rd_sel  = $urandom_range(0, 1) != 0;
      reset   = ($urandom_range(0, 199) != 0);
      tick();
    end
    reset = 1'b1; start = 1'b0; cancel = 1'b0;
    wait_idle(n);
    tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers for the P7 MIPS pipeline.
- Sits in the EX stage and consumes the decoded mult/multu/div/divu/mthi/mtlo/mfhi/mflo class.
- Models fixed MULT/DIV latencies with a busy counter so the hazard unit can stall HI/LO consumers.
- Honours the CP0 exception flush: an op arriving in the same cycle as a flush is killed; an op already in flight is not.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range >=1).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range >=1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  issue strobe for the op on `op`.
- op  in  3  MDU op code (package enum).
- rs_data  in  WIDTH  operand A; also the source for mthi/mtlo.
- rt_data  in  WIDTH  operand B.
- cancel  in  1  exception/eret flush from CP0; kills this cycle's issue.
- rd_sel  in  1  read select: 0 = LO, 1 = HI.
- busy  out  1  high while a mult/div is in flight.
- hi  out  WIDTH  architectural HI.
- lo  out  WIDTH  architectural LO.
- rd_data  out  WIDTH  combinational hi/lo mux on rd_sel (mfhi/mflo path).

Behaviour:
- Reset: reset sampled 0 at a clk edge clears hi, lo, the counter and pending registers, so busy=0 and rd_data=0. Reset mid-operation abandons the op; HI/LO stay 0.
- Accept condition is start & !cancel & !busy. Start while busy is ignored with no state change; the upstream stall logic guarantees this does not happen. Start with cancel=1 is ignored.
- MULT/MULTU on accept:
  - Compute the 2*WIDTH product (signed or unsigned) into the pending register.
  - Load counter = MULT_CYCLES.
- DIV/DIVU on accept:
  - Quotient goes to pending LO, remainder to pending HI.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - Signed overflow (min_int / -1) gives LO = min_int, HI = 0.
  - Divisor 0: no HI/LO commit (the counter still runs DIV_CYCLES).
  - Load counter = DIV_CYCLES.
- Counter and commit:
  - busy = (counter != 0).
  - Each edge with counter != 0 decrements it.
  - On the edge where it goes 1->0, pending HI/LO are written, so new values and busy=0 appear in the same cycle.
  - Exactly N busy cycles follow the accept edge.
- MTHI/MTLO on accept: write rs_data to hi/lo at that edge. No busy.
- MFHI/MFLO: no state change. Readers use rd_data.
- In-flight ops are never affected by cancel; only same-cycle issue is killed. This matches precise exceptions, because an op that reached the MDU before the faulting instruction retires.
- Ops not in the enum with start=1 are ignored.
- Arithmetic: product is full 2*WIDTH; HI = upper WIDTH bits, LO = lower WIDTH bits.

Decomposition:
- Shared package mdu_pkg:
  - Op enum: MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5, MDU_MFHI=6, MDU_MFLO=7.
  - Default latency constants.
  - The decoder's mulDiv class maps onto this enum.
- One sub-module, mdu_arith: combinational signed/unsigned product, quotient, remainder, div-by-zero flag and min_int/-1 handling. The top level holds the counter, pending registers and HI/LO.

Test Plan:
- MULT 0xFFFFFFFE x 0x00000003 (signed) -> busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA with busy=0 in the same cycle.
- MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA after 5 cycles.
- DIV -7 / 2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 / 0 -> busy for 10 cycles, then HI/LO unchanged.
- MTHI 0x12345678 with cancel=1 -> hi unchanged. Repeat with cancel=0 -> hi=0x12345678 next cycle, busy stays 0, rd_sel=1 gives rd_data=0x12345678.
- Start MULT, then assert cancel at busy cycle 2 -> op still commits on schedule. A second start issued while busy -> ignored, with no change to the counter or result.
- Drop reset to 0 at busy cycle 3 of a DIV -> next cycle hi=lo=0, busy=0. No late commit after reset is released.
